moore_sym_monitor: RTL and testbench
====================================

Name: moore_sym_monitor

Overview:
- Downstream consumer of the 2-bit Moore FSM output symbol stream (OutData) in the Moore lab datapath.
- Tracks the full A->B->C->D output signature 01,00,11,10, with self-loop repeats allowed, and counts completed signatures.
- Optionally flags excessive runs of one symbol.
- Reports events through a one-entry valid/ready event register with a sticky overrun flag.

Parameters:
- CNT_W, 8, width of the match counter and of EvtCount.
- RUN_MAX, 8, run length that triggers a run event. Legal range 2..2^CNT_W-1.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- SymValid  input  1  SymData qualifier; one symbol consumed per cycle when high.
- SymData  input  2  symbol from the Moore FSM OutData.
- EvtValid  output  1  event register holds an unconsumed event.
- EvtReady  input  1  consumer accepts the event this cycle.
- EvtCode  output  2  00 = signature match, 01 = run limit, 10/11 never produced.
- EvtCount  output  CNT_W  payload: match count after increment (match), or RUN_MAX (run).
- MatchCnt  output  CNT_W  running count of signatures; saturates at all-ones.
- Overrun  output  1  sticky; an event was lost.
- OvrClr  input  1  synchronous clear of Overrun.
- DetState  output  2  detector state for debug (IDLE=00, GOT1=01, GOT2=10, GOT3=11).

Behaviour:
- Reset (Reset=0, asynchronous): DetState=IDLE, EvtValid=0, EvtCode=00, EvtCount=0, MatchCnt=0, Overrun=0, internal RunCnt=0, internal previous-symbol register=00, prev-valid flag=0.
- Reset may assert mid-operation. It clears everything immediately, including a pending event. Release is synchronous to Clk; no symbol is consumed while Reset=0.
- State updates only on Clk edges with SymValid=1. SymValid=0 holds all detector and run state.
- Detector transitions, as symbol -> next state:
  - IDLE: 01 -> GOT1; otherwise IDLE.
  - GOT1: 01 -> GOT1; 00 -> GOT2; otherwise IDLE.
  - GOT2: 00 -> GOT2; 11 -> GOT3; 01 -> GOT1; 10 -> IDLE.
  - GOT3: 11 -> GOT3; 10 -> match, next IDLE; 01 -> GOT1; 00 -> IDLE.
- On a match:
  - MatchCnt increments, saturating at 2^CNT_W-1 (no wrap).
  - A match event is generated with EvtCount = the new MatchCnt.
- Event register:
  - A generated event is loaded if EvtValid=0, or if EvtValid=1 and EvtReady=1 in the same cycle (old event retires, new one loads, no overrun).
  - If EvtValid=1 and EvtReady=0, the new event is dropped, Overrun<=1, and the held event is unchanged.
  - EvtValid, EvtCode and EvtCount are stable while EvtValid=1 and EvtReady=0.
  - EvtValid clears on an EvtReady=1 cycle when no new event is generated.
- Latency: an event is visible on EvtValid one cycle after the Clk edge that consumes the completing symbol.
- Overrun:
  - Set has priority over OvrClr in the same cycle.
  - OvrClr=1 with no loss that cycle clears it the next cycle.
- Simultaneous match and run event in one cycle: the match event is loaded. The run event is dropped and Overrun<=1.

Optional Feature:
- Macro: MOORE_SYM_MONITOR_RUNLEN_EN.
- When defined:
  - RunCnt (CNT_W bits) tracks consecutive identical valid symbols.
  - First valid symbol after reset: RunCnt<=1.
  - Symbol different from the previous one: RunCnt<=1.
  - Symbol equal to the previous one: RunCnt+1. If the result equals RUN_MAX, generate a run event (EvtCode=01, EvtCount=RUN_MAX) and set RunCnt<=0, so the next equal symbol counts 1.
- When undefined:
  - No RunCnt logic.
  - EvtCode is only ever 00.
  - Run-related overrun cannot occur.

Test Plan:
- Reset, then SymValid=1 with symbols 01,00,11,10 -> DetState 01,10,11,00. EvtValid=1 one cycle after the 10 edge with EvtCode=00, EvtCount=1, MatchCnt=1.
- Symbols 01,01,00,00,00,11,11,10 -> one match event. Then symbols 01,00,10 -> DetState returns to IDLE on 10, no event.
- EvtReady=0, two full signatures -> first event held (EvtCount=1), Overrun=1, MatchCnt=2. OvrClr pulse -> Overrun=0. EvtReady pulse -> EvtValid=0.
- EvtReady=1 on the same cycle a second match completes -> EvtCount goes 1 to 2 with EvtValid staying 1 and Overrun=0.
- With MOORE_SYM_MONITOR_RUNLEN_EN, RUN_MAX=8: nine consecutive 11 symbols -> one run event (EvtCode=01, EvtCount=8) after the eighth symbol. The ninth symbol leaves RunCnt=1.
- Assert Reset mid-signature in GOT2 with EvtValid=1 -> all outputs return to reset values immediately. Post-release symbols 00,11,10 produce no match.

Source files
------------

// File: rtl/moore_sym_monitor_if.sv
// moore_sym_monitor_if
//   Bundles the symbol input stream, the valid/ready event register and
//   the status/debug outputs of moore_sym_monitor.
//   master : symbol producer / event consumer
//            (drives SymValid, SymData, EvtReady, OvrClr)
//   slave  : the monitor itself
//            (drives EvtValid, EvtCode, EvtCount, MatchCnt, Overrun, DetState)
//   CNT_W must match the CNT_W of the monitor it is attached to.
interface moore_sym_monitor_if #(parameter int CNT_W = 8);
  logic             SymValid;
  logic [1:0]       SymData;
  logic             EvtValid;
  logic             EvtReady;
  logic [1:0]       EvtCode;
  logic [CNT_W-1:0] EvtCount;
  logic [CNT_W-1:0] MatchCnt;
  logic             Overrun;
  logic             OvrClr;
  logic [1:0]       DetState;

  modport master (
    output SymValid, SymData, EvtReady, OvrClr,
    input  EvtValid, EvtCode, EvtCount, MatchCnt, Overrun, DetState
  );

  modport slave (
    input  SymValid, SymData, EvtReady, OvrClr,
    output EvtValid, EvtCode, EvtCount, MatchCnt, Overrun, DetState
  );
endinterface

// File: rtl/moore_sym_monitor.sv
// moore_sym_monitor
//   Watches the 2-bit Moore FSM output stream for the signature
//   01,00,11,10 (each symbol may repeat), counts completed signatures
//   (saturating) and reports each one through a one-entry valid/ready
//   event register. Events that cannot be loaded set a sticky Overrun.
//   Optional: define MOORE_SYM_MONITOR_RUNLEN_EN to also emit a run event
//   (EvtCode=01, EvtCount=RUN_MAX) each time RUN_MAX identical symbols
//   arrive back to back.
// Ports:
//   Clk   : rising-edge clock
//   Reset : asynchronous active-low reset
//   bus   : moore_sym_monitor_if.slave (symbol in, event out, status)
module moore_sym_monitor #(
  parameter int CNT_W   = 8,
  parameter int RUN_MAX = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  moore_sym_monitor_if.slave   bus
);

  typedef enum logic [1:0] {IDLE = 2'b00, GOT1 = 2'b01, GOT2 = 2'b10, GOT3 = 2'b11} det_state_e;

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic [CNT_W-1:0] evt_count_q, evt_count_d;
  logic             overrun_q, overrun_d;
  logic             match;
  logic             run_evt;
  logic             lose;

  // Signature detector.
  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (bus.SymValid) begin
      unique case (state_q)
        IDLE: state_d = (bus.SymData == 2'b01) ? GOT1 : IDLE;
        GOT1: begin
          case (bus.SymData)
            2'b01:   state_d = GOT1;
            2'b00:   state_d = GOT2;
            default: state_d = IDLE;
          endcase
        end
        GOT2: begin
          case (bus.SymData)
            2'b00:   state_d = GOT2;
            2'b11:   state_d = GOT3;
            2'b01:   state_d = GOT1;
            default: state_d = IDLE;
          endcase
        end
        GOT3: begin
          case (bus.SymData)
            2'b11:   state_d = GOT3;
            2'b10: begin
              state_d = IDLE;
              match   = 1'b1;
            end
            2'b01:   state_d = GOT1;
            default: state_d = IDLE;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Saturating match counter.
  always_comb begin
    match_cnt_d = match_cnt_q;
    if (match && (match_cnt_q != {CNT_W{1'b1}}))
      match_cnt_d = match_cnt_q + CNT_W'(1);
  end

`ifdef MOORE_SYM_MONITOR_RUNLEN_EN
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [1:0]       prev_sym_q, prev_sym_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] run_inc;

  always_comb begin
    run_cnt_d  = run_cnt_q;
    prev_sym_d = prev_sym_q;
    prev_vld_d = prev_vld_q;
    run_evt    = 1'b0;
    run_inc    = run_cnt_q + CNT_W'(1);
    if (bus.SymValid) begin
      prev_sym_d = bus.SymData;
      prev_vld_d = 1'b1;
      if (prev_vld_q && (bus.SymData == prev_sym_q)) begin
        // Restart at 0 on a hit so the next equal symbol counts as 1.
        if (run_inc == CNT_W'(RUN_MAX)) begin
          run_evt   = 1'b1;
          run_cnt_d = '0;
        end else begin
          run_cnt_d = run_inc;
        end
      end else begin
        run_cnt_d = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      run_cnt_q  <= '0;
      prev_sym_q <= 2'b00;
      prev_vld_q <= 1'b0;
    end else begin
      run_cnt_q  <= run_cnt_d;
      prev_sym_q <= prev_sym_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  assign run_evt = 1'b0;
`endif

  // Event register. A match wins over a simultaneous run event; the
  // losing run event counts as an overrun.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    evt_count_d = evt_count_q;
    lose        = 1'b0;
    if (match || run_evt) begin
      if (!evt_valid_q || bus.EvtReady) begin
        evt_valid_d = 1'b1;
        evt_code_d  = match ? 2'b00 : 2'b01;
        evt_count_d = match ? match_cnt_d : CNT_W'(RUN_MAX);
      end else begin
        lose = 1'b1;
      end
      if (match && run_evt) lose = 1'b1;
    end else if (bus.EvtReady) begin
      evt_valid_d = 1'b0;
    end
  end

  // Loss beats clear in the same cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (lose)            overrun_d = 1'b1;
    else if (bus.OvrClr) overrun_d = 1'b0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      match_cnt_q <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= 2'b00;
      evt_count_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      evt_count_q <= evt_count_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.DetState = state_q;
  assign bus.MatchCnt = match_cnt_q;
  assign bus.EvtValid = evt_valid_q;
  assign bus.EvtCode  = evt_code_q;
  assign bus.EvtCount = evt_count_q;
  assign bus.Overrun  = overrun_q;

endmodule

// File: tb/tb_moore_sym_monitor.sv
module tb_moore_sym_monitor;
  localparam int CNT_W   = 8;
  localparam int RUN_MAX = 8;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  moore_sym_monitor_if #(.CNT_W(CNT_W)) bus ();

  moore_sym_monitor #(.CNT_W(CNT_W), .RUN_MAX(RUN_MAX)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.SymValid = 1'b0; bus.SymData = 2'b00; bus.EvtReady = 1'b0; bus.OvrClr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One symbol per call, consumed on the next rising edge; outputs are
  // sampled 1ns after that edge.
  task automatic send(input logic [1:0] s, input logic rdy);
    @(negedge clk);
    bus.SymValid = 1'b1; bus.SymData = s; bus.EvtReady = rdy;
    @(posedge clk); #1;
    bus.SymValid = 1'b0; bus.EvtReady = 1'b0;
  endtask

  task automatic send_sig(input logic rdy_last);
    send(2'b01, 1'b0); send(2'b00, 1'b0); send(2'b11, 1'b0); send(2'b10, rdy_last);
  endtask

  task automatic pulse_rdy();
    @(negedge clk); bus.EvtReady = 1'b1;
    @(posedge clk); #1; bus.EvtReady = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk); bus.OvrClr = 1'b1;
    @(posedge clk); #1; bus.OvrClr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.SymValid = 1'b0; bus.SymData = 2'b00; bus.EvtReady = 1'b0; bus.OvrClr = 1'b0;
    #12;
    chk("rst_state",  bus.DetState, 0);
    chk("rst_valid",  bus.EvtValid, 0);
    chk("rst_code",   bus.EvtCode, 0);
    chk("rst_count",  bus.EvtCount, 0);
    chk("rst_mcnt",   bus.MatchCnt, 0);
    chk("rst_ovr",    bus.Overrun, 0);
    apply_reset();

    // Plain signature
    send(2'b01, 1'b0); chk("t1_s1", bus.DetState, 2'b01);
    send(2'b00, 1'b0); chk("t1_s2", bus.DetState, 2'b10);
    send(2'b11, 1'b0); chk("t1_s3", bus.DetState, 2'b11);
    chk("t1_novld", bus.EvtValid, 0);
    send(2'b10, 1'b0); chk("t1_s0", bus.DetState, 2'b00);
    chk("t1_vld",  bus.EvtValid, 1);
    chk("t1_code", bus.EvtCode, 0);
    chk("t1_cnt",  bus.EvtCount, 1);
    chk("t1_mcnt", bus.MatchCnt, 1);
    pulse_rdy();
    chk("t1_retire", bus.EvtValid, 0);

    // Repeated symbols, then an aborted signature
    send(2'b01, 1'b0); send(2'b01, 1'b0); send(2'b00, 1'b0); send(2'b00, 1'b0);
    send(2'b00, 1'b0); send(2'b11, 1'b0); send(2'b11, 1'b0);
    chk("t2_pre", bus.EvtValid, 0);
    send(2'b10, 1'b0);
    chk("t2_vld",  bus.EvtValid, 1);
    chk("t2_cnt",  bus.EvtCount, 2);
    pulse_rdy();
    send(2'b01, 1'b0); send(2'b00, 1'b0); send(2'b10, 1'b0);
    chk("t2_abort_st", bus.DetState, 0);
    chk("t2_abort_vld", bus.EvtValid, 0);
    chk("t2_abort_mcnt", bus.MatchCnt, 2);

    // Overrun with consumer stalled
    apply_reset();
    send_sig(1'b0); send_sig(1'b0);
    chk("t3_vld",  bus.EvtValid, 1);
    chk("t3_cnt",  bus.EvtCount, 1);
    chk("t3_ovr",  bus.Overrun, 1);
    chk("t3_mcnt", bus.MatchCnt, 2);
    pulse_clr();
    chk("t3_clr",   bus.Overrun, 0);
    chk("t3_hold",  bus.EvtValid, 1);
    pulse_rdy();
    chk("t3_retire", bus.EvtValid, 0);

    // Retire and load in the same cycle
    apply_reset();
    send_sig(1'b0);
    chk("t4_cnt1", bus.EvtCount, 1);
    send_sig(1'b1);
    chk("t4_vld",  bus.EvtValid, 1);
    chk("t4_cnt2", bus.EvtCount, 2);
    chk("t4_ovr",  bus.Overrun, 0);
    pulse_rdy();

    // Long run of one symbol
    for (int i = 0; i < 7; i++) send(2'b11, 1'b0);
    chk("t5_pre", bus.EvtValid, 0);
    send(2'b11, 1'b0);
`ifdef MOORE_SYM_MONITOR_RUNLEN_EN
    chk("t5_vld",  bus.EvtValid, 1);
    chk("t5_code", bus.EvtCode, 2'b01);
    chk("t5_cnt",  bus.EvtCount, RUN_MAX);
    send(2'b11, 1'b1);
    chk("t5_run1", dut.run_cnt_q, 1);
    chk("t5_retire", bus.EvtValid, 0);
`else
    send(2'b11, 1'b0);
    chk("t5_norun", bus.EvtValid, 0);
    chk("t5_code",  bus.EvtCode, 0);
`endif
    chk("t5_state", bus.DetState, 0);

    // Mid-signature asynchronous reset
    apply_reset();
    send_sig(1'b0);
    send(2'b01, 1'b0); send(2'b00, 1'b0);
    chk("t6_got2", bus.DetState, 2'b10);
    chk("t6_vld",  bus.EvtValid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_st",   bus.DetState, 0);
    chk("t6_rst_vld",  bus.EvtValid, 0);
    chk("t6_rst_cnt",  bus.EvtCount, 0);
    chk("t6_rst_mcnt", bus.MatchCnt, 0);
    chk("t6_rst_code", bus.EvtCode, 0);
    @(negedge clk); rst_n = 1'b1;
    send(2'b00, 1'b0); send(2'b11, 1'b0); send(2'b10, 1'b0);
    chk("t6_post_vld",  bus.EvtValid, 0);
    chk("t6_post_mcnt", bus.MatchCnt, 0);

    // Counter saturation
    apply_reset();
    for (int i = 0; i < 255; i++) send_sig(1'b1);
    chk("t7_mcnt255", bus.MatchCnt, 255);
    chk("t7_cnt255",  bus.EvtCount, 255);
    send_sig(1'b1);
    chk("t7_sat_mcnt", bus.MatchCnt, 255);
    chk("t7_sat_cnt",  bus.EvtCount, 255);
    chk("t7_sat_vld",  bus.EvtValid, 1);
    chk("t7_sat_ovr",  bus.Overrun, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
